// File: rtl/led_blink_arbiter.sv
// led_blink_arbiter: round-robin sharing of 8 LEDs between NUM_REQ blink-job requesters.
// Each granted job plays pattern-on / all-off phases of TICK_CYCLES each, then pulses done.
module led_blink_arbiter #(
    parameter int CLK_FREQ    = 25_000_000,
    parameter int NUM_REQ     = 4,
    parameter int TICK_CYCLES = CLK_FREQ / 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] pattern,
    input  logic [3*NUM_REQ-1:0] count,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic                 busy,
    output logic [7:0]           leds
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int TW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [3:0]           rem_q, rem_d;
    logic [PW-1:0]        rr_q, rr_d, sel;
    logic [7:0]           pat_q, pat_d, leds_d;
    logic [NUM_REQ-1:0]   grant_d, done_d;
    logic                 busy_d, tick_end;
    logic [7:0]           pat_a [NUM_REQ];
    logic [2:0]           cnt_a [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign pat_a[i] = pattern[8*i +: 8];
        assign cnt_a[i] = count[3*i +: 3];
    end

    // Walking backwards leaves the nearest requester after p as the winner.
    function automatic logic [PW-1:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [PW-1:0] p);
        logic [PW-1:0] idx;
        rr_pick = p;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = PW'((int'(p) + k) % NUM_REQ);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    assign sel      = rr_pick(req, rr_q);
    assign tick_end = tick_q == TW'(TICK_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            rem_q   <= '0;
            rr_q    <= PW'(NUM_REQ - 1);
            pat_q   <= '0;
            leds    <= '0;
            grant   <= '0;
            done    <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            rem_q   <= rem_d;
            rr_q    <= rr_d;
            pat_q   <= pat_d;
            leds    <= leds_d;
            grant   <= grant_d;
            done    <= done_d;
            busy    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        rem_d   = rem_q;
        rr_d    = rr_q;
        pat_d   = pat_q;
        if (state_q == IDLE) begin
            if (|req) begin
                state_d = ON;
                tick_d  = '0;
                rr_d    = sel;
                pat_d   = pat_a[sel];
                rem_d   = cnt_a[sel] == 3'd0 ? 4'd8 : {1'b0, cnt_a[sel]};
            end
        end else if (!req[rr_q]) begin
            state_d = IDLE;
            tick_d  = '0;
        end else if (tick_end) begin
            tick_d  = '0;
            state_d = state_q == ON ? OFF : (rem_q == 4'd1 ? IDLE : ON);
            rem_d   = state_q == OFF ? rem_q - 4'd1 : rem_q;
        end else begin
            tick_d  = tick_q + TW'(1);
        end
    end

    // Outputs are the registered image of the next state, so they line up with it.
    always_comb begin
        leds_d  = state_d == ON ? pat_d : 8'h00;
        grant_d = state_d == IDLE ? '0 : NUM_REQ'(1) << rr_d;
        busy_d  = state_d != IDLE;
        done_d  = (state_q == OFF && state_d == IDLE && req[rr_q]) ? NUM_REQ'(1) << rr_q : '0;
    end
endmodule

// File: tb/tb_led_blink_arbiter.sv
// tb_led_blink_arbiter: randomized bench against a job-position reference model.
// The model tracks owner, round-robin pointer and cycle offset within the job.
module tb_led_blink_arbiter;
    localparam int N = 4;
    localparam int T = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [8*N-1:0] pattern;
    logic [3*N-1:0] count;
    logic [N-1:0]   grant, done;
    logic           busy;
    logic [7:0]     leds;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int owner = -1;
    int ptr = N - 1;
    int pos = 0;
    int len = 0;
    logic [7:0]   m_pat = 8'h00;
    logic [N-1:0] m_done = '0;

    always #5 clk = ~clk;

    led_blink_arbiter #(.CLK_FREQ(16), .NUM_REQ(N), .TICK_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .pattern(pattern), .count(count),
        .grant(grant), .done(done), .busy(busy), .leds(leds)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h exp %0h", tag, cyc, got, exp);
        end
    endtask

    // A job of n blinks is 2*n*T cycles; offset pos lies in an ON phase when (pos/T) is even.
    task automatic model_step();
        int n;
        m_done = '0;
        if (!rst_n) begin
            owner = -1;
            ptr   = N - 1;
        end else if (owner < 0) begin
            if (req != '0) begin
                for (int k = 1; k <= N; k++) begin
                    if (owner < 0 && req[(ptr + k) % N]) owner = (ptr + k) % N;
                end
                ptr   = owner;
                m_pat = pattern[8*owner +: 8];
                n     = int'(count[3*owner +: 3]);
                len   = 2 * T * (n == 0 ? 8 : n);
                pos   = 0;
            end
        end else if (!req[owner]) begin
            owner = -1;
        end else if (pos == len - 1) begin
            m_done[owner] = 1'b1;
            owner = -1;
        end else begin
            pos++;
        end
    endtask

    task automatic cycle();
        logic [N-1:0] eg;
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        eg = owner < 0 ? '0 : N'(1) << owner;
        chk("grant", grant, eg);
        chk("done", done, m_done);
        chk("busy", busy, owner >= 0);
        chk("leds", leds, (owner >= 0 && (pos / T) % 2 == 0) ? m_pat : 8'h00);
        chk("busy_vs_grant", busy, |grant);
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = 4'b1111;
        pattern = {8'h3C, 8'h81, 8'hFF, 8'hA5};
        count   = {3'd1, 3'd3, 3'd0, 3'd2};
        repeat (3) cycle();
        rst_n = 1'b1;
        req   = 4'b0001;
        repeat (17) cycle();
        req = 4'b0000;
        repeat (3) cycle();
        req = 4'b0010;
        repeat (70) cycle();
        req   = 4'b1111;
        count = {3'd1, 3'd1, 3'd1, 3'd1};
        repeat (45) cycle();
        req   = 4'b0110;
        count = {3'd1, 3'd1, 3'd3, 3'd3};
        repeat (3) cycle();
        req = 4'b0100;
        repeat (12) cycle();
        req = 4'b0001;
        repeat (2) cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        req   = 4'b0011;
        repeat (4) cycle();
        for (int c = 0; c < 6000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 39) == 0) req[i] = ~req[i];
            end
            pattern = {$urandom, $urandom};
            count   = 12'($urandom);
            rst_n   = $urandom_range(0, 699) != 0;
            cycle();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
